// File: rtl/sim_mmio_slave.sv
// sim_mmio_slave: memory-mapped slave for simulation harnesses.
// A 256-byte region at BASE holds a UART TX byte FIFO, a status word,
// sticky pass/fail verdict flags and NTMR 64-bit cycle timers.
// Write and read channels are independent; READY strobes are combinational
// accept pulses and every response/data output comes from a register.
module sim_mmio_slave #(
  parameter int          DW   = 64,            // data width, 32 or 64
  parameter int          IDW  = 4,             // ID width
  parameter int          NTMR = 2,             // timer channels, 1..8
  parameter int          FDEP = 16,            // TX FIFO depth, power of two 2..256
  parameter logic [31:0] BASE = 32'h2000_0000  // region base, 256-byte aligned
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [IDW-1:0]  AWID,
  input  logic [31:0]     AWADDR,
  input  logic            AWVALID,
  output logic            AWREADY,
  input  logic [DW-1:0]   WDATA,
  input  logic [DW/8-1:0] WSTRB,
  input  logic            WVALID,
  output logic            WREADY,
  output logic [IDW-1:0]  BID,
  output logic [1:0]      BRESP,
  output logic            BVALID,
  input  logic            BREADY,
  input  logic [IDW-1:0]  ARID,
  input  logic [31:0]     ARADDR,
  input  logic            ARVALID,
  output logic            ARREADY,
  output logic [IDW-1:0]  RID,
  output logic [DW-1:0]   RDATA,
  output logic [1:0]      RRESP,
  output logic            RVALID,
  input  logic            RREADY,
  output logic [7:0]      TX_DATA,
  output logic            TX_VALID,
  input  logic            TX_READY,
  output logic            SUCCESS,
  output logic            FAIL
);

  localparam int PW = $clog2(FDEP);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] OFF_UART    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h08;
  localparam logic [7:0] OFF_CTRL    = 8'h10;
  localparam logic [7:0] OFF_TMR0    = 8'h20;
  localparam logic [7:0] OFF_TMR_END = 8'(32 + 8 * NTMR);

  localparam logic [2:0] TGT_UART   = 3'd0;
  localparam logic [2:0] TGT_STATUS = 3'd1;
  localparam logic [2:0] TGT_CTRL   = 3'd2;
  localparam logic [2:0] TGT_TMR    = 3'd3;
  localparam logic [2:0] TGT_NONE   = 3'd4;

  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  // Map an address onto one of the register targets (TGT_NONE = unmapped).
  function automatic logic [2:0] decode_tgt(input logic [31:0] addr);
    logic [2:0] tgt;
    if (addr[31:8] != BASE[31:8]) begin
      tgt = TGT_NONE;
    end else begin
      case (addr[7:0])
        OFF_UART:   tgt = TGT_UART;
        OFF_STATUS: tgt = TGT_STATUS;
        OFF_CTRL:   tgt = TGT_CTRL;
        default: begin
          if ((addr[7:0] >= OFF_TMR0) && (addr[7:0] < OFF_TMR_END) && (addr[2:0] == 3'b000)) begin
            tgt = TGT_TMR;
          end else begin
            tgt = TGT_NONE;
          end
        end
      endcase
    end
    return tgt;
  endfunction

  // Timer slots start at 0x20, i.e. slot number 4 in units of 8 bytes;
  // the mapped range 0x20..0x5F keeps this subtraction free of aliasing.
  function automatic logic [2:0] tmr_index(input logic [31:0] addr);
    return addr[5:3] - 3'd4;
  endfunction

  // Byte strobes carry no meaning here: every access is a full-word access.
  logic unused_strb_s;
  assign unused_strb_s = ^{WSTRB, 1'b0};

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [PW:0]            wr_ptr_r, rd_ptr_r;
  logic [7:0]             fifo_mem_r [FDEP];
  logic                   bvalid_r, rvalid_r;
  logic [IDW-1:0]         bid_r, rid_r;
  logic [1:0]             bresp_r, rresp_r;
  logic [DW-1:0]          rdata_r;
  logic                   success_r, fail_r;
  logic [NTMR-1:0][63:0]  tmr_cnt_r;
  logic [NTMR-1:0]        tmr_run_r;

  // ------------------------------------------------------------------
  // Combinational decode
  // ------------------------------------------------------------------
  logic [PW:0]           fifo_cnt_s;
  logic                  fifo_empty_s, fifo_full_s;
  logic                  push_s, pop_s;
  logic [2:0]            wr_tgt_s, rd_tgt_s;
  logic [2:0]            wr_idx_s, rd_idx_s;
  logic                  wr_acc_s, rd_acc_s, wr_stall_s;
  logic [1:0]            wr_resp_s, rd_resp_s;
  logic [DW-1:0]         rd_data_s, tmr_rd_s;
  logic                  set_success_s, set_fail_s;
  logic [NTMR-1:0]       tmr_start_s, tmr_stop_s, tmr_clr_s;

  assign fifo_cnt_s   = wr_ptr_r - rd_ptr_r;
  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);

  assign wr_tgt_s = decode_tgt(AWADDR);
  assign wr_idx_s = tmr_index(AWADDR);
  assign rd_tgt_s = decode_tgt(ARADDR);
  assign rd_idx_s = tmr_index(ARADDR);

  // A UART write to a full FIFO waits rather than dropping the byte.
  assign wr_stall_s = (wr_tgt_s == TGT_UART) && fifo_full_s;
  assign wr_acc_s   = !RST && AWVALID && WVALID && !bvalid_r && !wr_stall_s;
  assign rd_acc_s   = !RST && ARVALID && !rvalid_r;

  assign push_s = wr_acc_s && (wr_tgt_s == TGT_UART);
  assign pop_s  = !fifo_empty_s && TX_READY;

  assign set_success_s = wr_acc_s && (wr_tgt_s == TGT_CTRL) && (WDATA == DW'(2'd1));
  assign set_fail_s    = wr_acc_s && (wr_tgt_s == TGT_CTRL) && (WDATA == DW'(2'd2));

  // Write response code: only UART, CTRL and existing timers are writable.
  always_comb begin
    case (wr_tgt_s)
      TGT_UART: wr_resp_s = RESP_OKAY;
      TGT_CTRL: wr_resp_s = RESP_OKAY;
      TGT_TMR:  wr_resp_s = RESP_OKAY;
      default:  wr_resp_s = RESP_SLVERR;
    endcase
  end

  // Per-timer command strobes from an accepted timer write.
  always_comb begin
    tmr_start_s = '0;
    tmr_stop_s  = '0;
    tmr_clr_s   = '0;
    for (int i = 0; i < NTMR; i++) begin
      if (wr_acc_s && (wr_tgt_s == TGT_TMR) && (wr_idx_s == 3'(i))) begin
        tmr_stop_s[i]  = (WDATA == DW'(2'd0));
        tmr_start_s[i] = (WDATA == DW'(2'd1));
        tmr_clr_s[i]   = (WDATA == DW'(2'd2));
      end else begin
        tmr_stop_s[i]  = 1'b0;
        tmr_start_s[i] = 1'b0;
        tmr_clr_s[i]   = 1'b0;
      end
    end
  end

  // Select the addressed timer's low DW bits for a read.
  always_comb begin
    tmr_rd_s = '0;
    for (int i = 0; i < NTMR; i++) begin
      tmr_rd_s = (rd_idx_s == 3'(i)) ? tmr_cnt_r[i][DW-1:0] : tmr_rd_s;
    end
  end

  // Read data/response mux; unmapped reads return zero with SLVERR.
  always_comb begin
    rd_data_s = '0;
    rd_resp_s = RESP_OKAY;
    case (rd_tgt_s)
      TGT_UART:   rd_data_s = DW'(fifo_cnt_s);
      TGT_STATUS: rd_data_s = DW'({fail_r, success_r, fifo_full_s, fifo_empty_s});
      TGT_CTRL:   rd_data_s = DW'({fail_r, success_r});
      TGT_TMR:    rd_data_s = tmr_rd_s;
      default: begin
        rd_data_s = '0;
        rd_resp_s = RESP_SLVERR;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Sequential logic
  // ------------------------------------------------------------------

  // Write response channel: raise BVALID after acceptance, drop on BREADY.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bvalid_r <= 1'b0;
      bid_r    <= '0;
      bresp_r  <= RESP_OKAY;
    end else if (wr_acc_s) begin
      bvalid_r <= 1'b1;
      bid_r    <= AWID;
      bresp_r  <= wr_resp_s;
    end else if (BREADY) begin
      bvalid_r <= 1'b0;
    end
  end

  // Read data channel: capture data at acceptance, hold until RREADY.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rvalid_r <= 1'b0;
      rid_r    <= '0;
      rresp_r  <= RESP_OKAY;
      rdata_r  <= '0;
    end else if (rd_acc_s) begin
      rvalid_r <= 1'b1;
      rid_r    <= ARID;
      rresp_r  <= rd_resp_s;
      rdata_r  <= rd_data_s;
    end else if (RREADY) begin
      rvalid_r <= 1'b0;
    end
  end

  // FIFO pointers: wrap bit plus PW index bits, each advanced independently.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // FIFO storage: payload only, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[PW-1:0]] <= WDATA[7:0];
    end
  end

  // Sticky verdict flags, cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      success_r <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      success_r <= success_r | set_success_s;
      fail_r    <= fail_r | set_fail_s;
    end
  end

  // Cycle timers: clear beats increment; run flag follows start/stop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmr_cnt_r <= '0;
      tmr_run_r <= '0;
    end else begin
      for (int i = 0; i < NTMR; i++) begin
        if (tmr_clr_s[i]) begin
          tmr_cnt_r[i] <= 64'd0;
        end else if (tmr_run_r[i]) begin
          tmr_cnt_r[i] <= tmr_cnt_r[i] + 64'd1;
        end
        if (tmr_start_s[i]) begin
          tmr_run_r[i] <= 1'b1;
        end else if (tmr_stop_s[i]) begin
          tmr_run_r[i] <= 1'b0;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign AWREADY  = wr_acc_s;
  assign WREADY   = wr_acc_s;
  assign ARREADY  = rd_acc_s;
  assign BVALID   = bvalid_r;
  assign BID      = bid_r;
  assign BRESP    = bresp_r;
  assign RVALID   = rvalid_r;
  assign RID      = rid_r;
  assign RRESP    = rresp_r;
  assign RDATA    = rdata_r;
  assign TX_VALID = !fifo_empty_s;
  assign TX_DATA  = fifo_mem_r[rd_ptr_r[PW-1:0]];
  assign SUCCESS  = success_r;
  assign FAIL     = fail_r;

endmodule

// File: doc/sim_mmio_slave.md
SIM_MMIO_SLAVE -- requirements
Module: sim_mmio_slave

Interface
REQ-001 Parameter DW, default 64, meaning AXI data width; legal values are 32 or 64 only.
REQ-002 Parameter IDW, default 4, meaning AXI ID width.
REQ-003 Parameter NTMR, default 2, meaning number of cycle-timer channels; legal range is 1..8.
REQ-004 Parameter FDEP, default 16, meaning TX byte FIFO depth; must be a power of two, 2..256.
REQ-005 Parameter BASE, default 32'h20000000, meaning region base address; must be 256-byte aligned.
REQ-006 Ports are as follows; CLK and RST come first.
- CLK, in, 1: sole clock.
- RST, in, 1: reset; asynchronous and active-high.
- AWID, in, IDW; AWADDR, in, 32; AWVALID, in, 1; AWREADY, out, 1.
- WDATA, in, DW; WSTRB, in, DW/8; WVALID, in, 1; WREADY, out, 1.
- BID, out, IDW; BRESP, out, 2; BVALID, out, 1; BREADY, in, 1.
- ARID, in, IDW; ARADDR, in, 32; ARVALID, in, 1; ARREADY, out, 1.
- RID, out, IDW; RDATA, out, DW; RRESP, out, 2; RVALID, out, 1; RREADY, in, 1.
- TX_DATA, out, 8; TX_VALID, out, 1; TX_READY, in, 1: TX byte stream drained from the FIFO.
- SUCCESS, out, 1 and FAIL, out, 1: sticky test verdicts.

Function
REQ-007 Address map, decoded on ADDR[7:0] with ADDR[31:8] required to equal BASE[31:8]:
- 0x00 UART: W pushes WDATA[7:0]; R returns the FIFO count.
- 0x08 STATUS: RO; bit0 = FIFO empty, bit1 = FIFO full, bit2 = SUCCESS, bit3 = FAIL.
- 0x10 CTRL: W 1 sets SUCCESS; W 2 sets FAIL; any other value is ignored.
- 0x20+8*i TIMER i: W 0 stops, W 1 starts, W 2 clears the count (run state unchanged); R returns count[DW-1:0].
REQ-008 Any other offset, any address outside the region, and any write to STATUS return SLVERR (2'b10), with no side effect and RDATA = 0.
REQ-009 Write handshake:
- AWREADY and WREADY are pulsed high together for exactly one cycle.
- The pulse occurs when AWVALID & WVALID are both high, BVALID is low, and the target is not UART with the FIFO full.
- The write takes effect on that accepting edge.
REQ-010 BVALID rises the cycle after acceptance, with BID set to the accepted AWID, and holds until BREADY is high; no new write is accepted while BVALID is high.
REQ-011 Read handshake:
- ARREADY is pulsed for one cycle when ARVALID is high and RVALID is low.
- RDATA is sampled at acceptance.
- RVALID rises the next cycle with RID set to ARID, and holds until RREADY.
REQ-012 Reads and writes proceed independently; a read and a write accepted in the same cycle are both legal. A read returns pre-write state.
REQ-013 WSTRB is ignored; full-word semantics apply.
REQ-014 FIFO behaviour:
- TX_VALID = not empty and TX_DATA = head byte; a pop occurs on TX_VALID & TX_READY.
- A push and a pop in the same cycle leave the count unchanged.
- Pushes are never dropped; a UART write to a full FIFO stalls until space frees.
- Pointers are log2(FDEP) bits plus a wrap bit and wrap modulo FDEP.
- Count range is 0..FDEP.
REQ-015 Each timer has a 64-bit count that increments by 1 per cycle while running and wraps from 2^64-1 to 0.
REQ-016 A start write makes the timer run from the next cycle. A stop write freezes the count from the next cycle. A clear write zeroes the count on the accepting edge, taking priority over the increment.
REQ-017 SUCCESS and FAIL are sticky until reset; both may be high.

Reset
REQ-018 While RST is high, the following are all 0:
- All READY and VALID outputs, BID/RID, RDATA, and the FIFO pointers.
- All timer counts and run flags, and SUCCESS and FAIL.
REQ-019 RST asserted mid-transaction aborts it with no response issued; operation resumes on the first edge after RST falls.

Verification
REQ-020 Write UART 0x41, 0x42 with TX_READY=1 -> TX_DATA shows 0x41 then 0x42, with BRESP=0 on each write.
REQ-021 With TX_READY=0, push FDEP+1 bytes -> the last write stalls with AWREADY low and STATUS bit1=1; raise TX_READY -> the stalled write completes and the bytes drain in order.
REQ-022 Timer0 sequence: W 1 to 0x20, idle 100 cycles, W 0, then read 0x20 -> a fixed count (DUT-measured and equal on reruns); W 2 then read -> 0.
REQ-023 Write CTRL=1 -> SUCCESS=1, FAIL=0, and STATUS reads bit2=1; then write CTRL=2 -> FAIL=1 and SUCCESS stays 1.
REQ-024 Read offset 0x18, and write address 0x30000000 -> RRESP and BRESP are both 2'b10, with RDATA=0.
REQ-025 Assert RST while BVALID is high with BREADY=0 -> BVALID=0 immediately; a subsequent write completes normally.
